sat_core_bin_port: RTL and testbench
====================================

Name: sat_core_bin_port

Overview:
Sat-engine-side endpoint of the bin_manager load/update interface. It holds one bin: NUM_CLAUSES_A_BIN clause rows, NUM_VARS_A_BIN var states and NUM_LVLS_A_BIN lvl states. It accepts one-hot row writes, returns registered row reads, and answers the start_core/done_core handshake with a local sat/unsat verdict after a fixed evaluation latency. It stands in for the core in bin_manager system benches and is the shell the real core will plug into.

Parameters:
NUM_CLAUSES_A_BIN, 8, clause rows per bin
NUM_VARS_A_BIN, 8, vars per bin; clause width = 2*NUM_VARS_A_BIN
NUM_LVLS_A_BIN, 8, lvl-state entries per bin
WIDTH_LVL, 16, level width
WIDTH_BIN_ID, 10, bin id width
WIDTH_VAR_STATES, 19, var state = {value[2], implied[1], level[WIDTH_LVL]}
WIDTH_LVL_STATES, 11, lvl state = {dcd_bin[WIDTH_BIN_ID], has_bkt[1]}
EVAL_LAT, 4, cycles in RUN before done (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start_core_i  in  1  one-cycle start pulse
done_core_o  out  1  one-cycle done pulse
local_sat_o  out  1  verdict: all non-empty clauses satisfied
local_unsat_o  out  1  verdict: some non-empty clause has all literals false
wr_carray_i  in  NUM_CLAUSES_A_BIN  one-hot (or multi-hot) row write enables
rd_carray_i  in  NUM_CLAUSES_A_BIN  one-hot row read select
clause_i  in  2*NUM_VARS_A_BIN  write data
clause_o  out  2*NUM_VARS_A_BIN  read data
wr_var_states_i  in  NUM_VARS_A_BIN  per-var write enables
vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  packed var states in
vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS_A_BIN  packed var states, live
wr_lvl_states_i  in  NUM_LVLS_A_BIN  per-entry write enables
lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  packed lvl states in
lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  packed lvl states, live
base_lvl_en_i  in  1  base level load strobe
base_lvl_i  in  WIDTH_LVL  base level
cur_lvl_o  out  WIDTH_LVL  current level (latched base level)

Behaviour:
- Reset (rst=0, async): all storage cleared to 0; clause_o, vars_states_o, lvl_states_o, cur_lvl_o = 0; done_core_o, local_sat_o, local_unsat_o = 0; FSM = IDLE.
- Literal encoding: 2 bits per var. 00 = absent, 10 = positive, 01 = negative, 11 = illegal (treated as absent).
- Var value encoding: 00 = free, 10 = true, 01 = false.
- A literal is true iff lit == value and lit != 00. A literal is false iff the value is non-free, lit is non-absent, and lit != value.
- Storage updates are allowed only in IDLE.
  - Every row i with wr_carray_i[i]=1 takes clause_i at the clock edge; multi-hot writes all selected rows.
  - Var and lvl writes take the corresponding slice of vars_states_i / lvl_states_i per enable bit.
  - Writes arriving in RUN or DONE are dropped.
- Read:
  - rd_carray_i with one bit set in cycle N gives clause_o = that row in cycle N+1.
  - Multi-hot select: lowest set index wins.
  - All-zero select: clause_o holds its last value.
  - Read and write to the same row in the same cycle return the old data.
  - Reads are allowed in every state.
- vars_states_o / lvl_states_o are direct register outputs: new data is visible the cycle after the write.
- base_lvl_en_i loads cur_lvl_o next cycle, in any state.
- FSM:
  - IDLE: start_core_i goes to RUN; counter loads EVAL_LAT-1; local_sat_o and local_unsat_o clear.
  - RUN: counter decrements each cycle; at 0 go to DONE. start_core_i is ignored.
  - DONE (1 cycle): done_core_o=1; local_sat_o/local_unsat_o register the evaluated verdict and hold it until the next accepted start; next state is IDLE.
  - done_core_o therefore rises EVAL_LAT+1 cycles after the start pulse.
- Verdict (evaluated on storage contents in the RUN cycle where counter=0):
  - A row is empty if all of its literals are absent.
  - unsat = some non-empty row has every present literal false.
  - sat = not unsat, and every non-empty row has at least one true literal.
  - If both conditions could hold, unsat wins. An all-empty bin gives sat=1.
  - When neither holds (free vars remain), both outputs are 0 and done is still pulsed.
- Reset mid-RUN aborts to IDLE with no done pulse.

Test Plan:
- Reset: drive rst=0 during activity, release -> all outputs 0, clause_o=0, FSM idle (a start then gives done 5 cycles later at EVAL_LAT=4).
- Write then read: write row3=16'h8002 and row5=16'h0140, then rd_carray_i=8'b0010_0000 -> clause_o=16'h0140 the next cycle; rd=8'b0010_1000 -> 16'h8002 (lowest index wins).
- Sat: rows {v0 pos}, {v1 neg, v2 pos}, var values v0=10, v1=10, v2=10, start -> done at +5 cycles with local_sat_o=1, local_unsat_o=0.
- Unsat: row {v0 pos, v1 pos} with v0=01, v1=01 -> done with local_unsat_o=1, local_sat_o=0. Same clause with v1=00 -> both outputs 0.
- Lockout: during RUN, write row0 and pulse start again -> row0 unchanged on readback, exactly one done pulse; after done, a write succeeds.
- Lvl/base: write lvl entry 2 = {10'd7, 1'b1}, base_lvl_en_i with base_lvl_i=16'd3 -> lvl_states_o[32:22]=11'h00F next cycle, cur_lvl_o=3.

Source files
------------

// File: rtl/sat_core_bin_port.sv
// Sat-engine endpoint of the bin_manager load/update interface: holds one bin of
// clauses, var states and lvl states, and answers start_core with a sat/unsat verdict.
module sat_core_bin_port #(
  parameter int NUM_CLAUSES_A_BIN = 8,
  parameter int NUM_VARS_A_BIN    = 8,
  parameter int NUM_LVLS_A_BIN    = 8,
  parameter int WIDTH_LVL         = 16,
  parameter int WIDTH_BIN_ID      = 10,
  parameter int WIDTH_VAR_STATES  = 19,
  parameter int WIDTH_LVL_STATES  = 11,
  parameter int EVAL_LAT          = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start_core_i,
  output logic                                         done_core_o,
  output logic                                         local_sat_o,
  output logic                                         local_unsat_o,
  input  logic [NUM_CLAUSES_A_BIN-1:0]                 wr_carray_i,
  input  logic [NUM_CLAUSES_A_BIN-1:0]                 rd_carray_i,
  input  logic [2*NUM_VARS_A_BIN-1:0]                  clause_i,
  output logic [2*NUM_VARS_A_BIN-1:0]                  clause_o,
  input  logic [NUM_VARS_A_BIN-1:0]                    wr_var_states_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   vars_states_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   vars_states_o,
  input  logic [NUM_LVLS_A_BIN-1:0]                    wr_lvl_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_o,
  input  logic                                         base_lvl_en_i,
  input  logic [WIDTH_LVL-1:0]                         base_lvl_i,
  output logic [WIDTH_LVL-1:0]                         cur_lvl_o
);

  localparam int CW    = 2 * NUM_VARS_A_BIN;
  localparam int VW    = WIDTH_VAR_STATES * NUM_VARS_A_BIN;
  localparam int LW    = WIDTH_LVL_STATES * NUM_LVLS_A_BIN;
  localparam int IDX_W = (NUM_CLAUSES_A_BIN > 1) ? $clog2(NUM_CLAUSES_A_BIN) : 1;
  localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   sat_r, sat_nxt_s;
  logic                   unsat_r, unsat_nxt_s;
  logic [CW-1:0]          clause_mem_r [NUM_CLAUSES_A_BIN];
  logic [CW-1:0]          clause_rd_r;
  logic [VW-1:0]          vars_r;
  logic [LW-1:0]          lvls_r;
  logic [WIDTH_LVL-1:0]   cur_lvl_r;
  logic [IDX_W-1:0]       rd_idx_s;
  logic                   wr_en_s;
  logic                   any_unsat_s;
  logic                   all_ok_s;

  // Only 10/01 are real literals; 11 is folded into "absent".
  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == 2'b10) || (lit == 2'b01);
  endfunction

  // Row conflicts: non-empty and every present literal is contradicted by an assigned var.
  function automatic logic row_unsat(input logic [CW-1:0] clause, input logic [VW-1:0] vars);
    logic       any_present;
    logic       all_false;
    logic [1:0] lit;
    logic [1:0] val;
    any_present = 1'b0;
    all_false   = 1'b1;
    for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
      lit = clause[2*v +: 2];
      val = vars[v*WIDTH_VAR_STATES + WIDTH_VAR_STATES - 2 +: 2];
      if (lit_present(lit)) begin
        any_present = 1'b1;
        if ((val == 2'b00) || (lit == val)) begin
          all_false = 1'b0;
        end else begin
          all_false = all_false;
        end
      end else begin
        any_present = any_present;
      end
    end
    return any_present && all_false;
  endfunction

  // Row is fine for sat: empty, or at least one literal matches its var value.
  function automatic logic row_ok(input logic [CW-1:0] clause, input logic [VW-1:0] vars);
    logic       any_present;
    logic       any_true;
    logic [1:0] lit;
    logic [1:0] val;
    any_present = 1'b0;
    any_true    = 1'b0;
    for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
      lit = clause[2*v +: 2];
      val = vars[v*WIDTH_VAR_STATES + WIDTH_VAR_STATES - 2 +: 2];
      if (lit_present(lit)) begin
        any_present = 1'b1;
        any_true    = any_true || (lit == val);
      end else begin
        any_present = any_present;
      end
    end
    return !any_present || any_true;
  endfunction

  assign wr_en_s = (state_r == IDLE);

  // Bin-wide verdict over the current storage contents.
  always_comb begin
    any_unsat_s = 1'b0;
    all_ok_s    = 1'b1;
    for (int r = 0; r < NUM_CLAUSES_A_BIN; r++) begin
      any_unsat_s = any_unsat_s || row_unsat(clause_mem_r[r], vars_r);
      all_ok_s    = all_ok_s && row_ok(clause_mem_r[r], vars_r);
    end
  end

  // Lowest set read-select bit picks the row.
  always_comb begin
    rd_idx_s = '0;
    for (int i = NUM_CLAUSES_A_BIN - 1; i >= 0; i--) begin
      if (rd_carray_i[i]) begin
        rd_idx_s = IDX_W'(i);
      end else begin
        rd_idx_s = rd_idx_s;
      end
    end
  end

  // Clause storage and registered read port (read sees pre-write data).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLAUSES_A_BIN; i++) begin
        clause_mem_r[i] <= '0;
      end
      clause_rd_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CLAUSES_A_BIN; i++) begin
        if (wr_en_s && wr_carray_i[i]) begin
          clause_mem_r[i] <= clause_i;
        end
      end
      if (|rd_carray_i) begin
        clause_rd_r <= clause_mem_r[rd_idx_s];
      end
    end
  end

  // Var/lvl state storage and current level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vars_r    <= '0;
      lvls_r    <= '0;
      cur_lvl_r <= '0;
    end else begin
      for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
        if (wr_en_s && wr_var_states_i[v]) begin
          vars_r[v*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <=
            vars_states_i[v*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
        end
      end
      for (int l = 0; l < NUM_LVLS_A_BIN; l++) begin
        if (wr_en_s && wr_lvl_states_i[l]) begin
          lvls_r[l*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <=
            lvl_states_i[l*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
        end
      end
      if (base_lvl_en_i) begin
        cur_lvl_r <= base_lvl_i;
      end
    end
  end

  // FSM next state, countdown and verdict capture.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
    sat_nxt_s   = sat_r;
    unsat_nxt_s = unsat_r;
    case (state_r)
      IDLE: begin
        if (start_core_i) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_W'(EVAL_LAT - 1);
          sat_nxt_s   = 1'b0;
          unsat_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == '0) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
          unsat_nxt_s = any_unsat_s;
          sat_nxt_s   = !any_unsat_s && all_ok_s;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM and handshake output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      done_r  <= 1'b0;
      sat_r   <= 1'b0;
      unsat_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
      sat_r   <= sat_nxt_s;
      unsat_r <= unsat_nxt_s;
    end
  end

  assign done_core_o   = done_r;
  assign local_sat_o   = sat_r;
  assign local_unsat_o = unsat_r;
  assign clause_o      = clause_rd_r;
  assign vars_states_o = vars_r;
  assign lvl_states_o  = lvls_r;
  assign cur_lvl_o     = cur_lvl_r;

endmodule

// File: tb/tb_sat_core_bin_port.sv
// Scoreboard bench for sat_core_bin_port: a driver updates a behavioural bin model
// and queues expectations; a monitor compares them as the DUT presents outputs.
module tb_sat_core_bin_port;
  localparam int NC  = 8;
  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WL  = 16;
  localparam int WB  = 10;
  localparam int WV  = 19;
  localparam int WLS = 11;
  localparam int EL  = 4;
  localparam int CW  = 2 * NV;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_core_i = 1'b0;
  logic              done_core_o, local_sat_o, local_unsat_o;
  logic [NC-1:0]     wr_carray_i = '0;
  logic [NC-1:0]     rd_carray_i = '0;
  logic [CW-1:0]     clause_i = '0;
  logic [CW-1:0]     clause_o;
  logic [NV-1:0]     wr_var_states_i = '0;
  logic [WV*NV-1:0]  vars_states_i = '0;
  logic [WV*NV-1:0]  vars_states_o;
  logic [NL-1:0]     wr_lvl_states_i = '0;
  logic [WLS*NL-1:0] lvl_states_i = '0;
  logic [WLS*NL-1:0] lvl_states_o;
  logic              base_lvl_en_i = 1'b0;
  logic [WL-1:0]     base_lvl_i = '0;
  logic [WL-1:0]     cur_lvl_o;

  sat_core_bin_port #(
    .NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .NUM_LVLS_A_BIN(NL),
    .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_VAR_STATES(WV),
    .WIDTH_LVL_STATES(WLS), .EVAL_LAT(EL)
  ) dut (
    .clk(clk), .rst(rst), .start_core_i(start_core_i), .done_core_o(done_core_o),
    .local_sat_o(local_sat_o), .local_unsat_o(local_unsat_o),
    .wr_carray_i(wr_carray_i), .rd_carray_i(rd_carray_i), .clause_i(clause_i),
    .clause_o(clause_o), .wr_var_states_i(wr_var_states_i),
    .vars_states_i(vars_states_i), .vars_states_o(vars_states_o),
    .wr_lvl_states_i(wr_lvl_states_i), .lvl_states_i(lvl_states_i),
    .lvl_states_o(lvl_states_o), .base_lvl_en_i(base_lvl_en_i),
    .base_lvl_i(base_lvl_i), .cur_lvl_o(cur_lvl_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   edge_n;
    logic sat;
    logic unsat;
  } verdict_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_done = 0;

  verdict_t       vq[$];
  logic [CW-1:0]  rdq[$];

  // Behavioural bin model
  logic [CW-1:0]     m_clause [NC];
  logic [WV*NV-1:0]  m_vars;
  logic [WLS*NL-1:0] m_lvls;
  logic [WL-1:0]     m_cur;
  int                busy_lo = 1;
  int                busy_hi = 0;

  // Next-cycle stimulus
  logic [NC-1:0]     n_wr_c, n_rd;
  logic [CW-1:0]     n_clause;
  logic [NV-1:0]     n_wr_v;
  logic [WV*NV-1:0]  n_vars;
  logic [NL-1:0]     n_wr_l;
  logic [WLS*NL-1:0] n_lvls;
  logic              n_ben, n_start;
  logic [WL-1:0]     n_base;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A clause is judged from the literal list it names; values come from the var model.
  function automatic void ref_verdict(output logic sat, output logic unsat);
    int present, n_true, n_false;
    logic [1:0] lit, val;
    logic all_rows_ok;
    unsat = 1'b0;
    all_rows_ok = 1'b1;
    for (int r = 0; r < NC; r++) begin
      present = 0; n_true = 0; n_false = 0;
      for (int v = 0; v < NV; v++) begin
        lit = m_clause[r][2*v +: 2];
        val = m_vars[v*WV + 17 +: 2];
        if (lit == 2'b10 || lit == 2'b01) begin
          present++;
          if (lit == val) n_true++;
          else if (val != 2'b00) n_false++;
        end
      end
      if (present > 0 && n_false == present) unsat = 1'b1;
      if (present > 0 && n_true == 0) all_rows_ok = 1'b0;
    end
    sat = !unsat && all_rows_ok;
  endfunction

  task automatic clear_next();
    n_wr_c = '0; n_rd = '0; n_clause = '0; n_wr_v = '0; n_vars = '0;
    n_wr_l = '0; n_lvls = '0; n_ben = 1'b0; n_start = 1'b0; n_base = '0;
  endtask

  task automatic clear_model();
    for (int r = 0; r < NC; r++) m_clause[r] = '0;
    m_vars = '0; m_lvls = '0; m_cur = '0;
    busy_lo = 1; busy_hi = 0;
    vq.delete(); rdq.delete();
  endtask

  // One clock: drive the queued stimulus, then advance the model for that edge.
  task automatic step();
    int e, idx;
    logic idle, s, u;
    @(negedge clk);
    wr_carray_i = n_wr_c; rd_carray_i = n_rd; clause_i = n_clause;
    wr_var_states_i = n_wr_v; vars_states_i = n_vars;
    wr_lvl_states_i = n_wr_l; lvl_states_i = n_lvls;
    base_lvl_en_i = n_ben; base_lvl_i = n_base; start_core_i = n_start;
    e = cyc + 1;
    @(posedge clk);
    idle = !(e >= busy_lo && e <= busy_hi);
    if (n_rd != '0) begin
      idx = 0;
      while (!n_rd[idx]) idx++;
      rdq.push_back(m_clause[idx]);
    end
    if (idle) begin
      for (int r = 0; r < NC; r++) if (n_wr_c[r]) m_clause[r] = n_clause;
      for (int v = 0; v < NV; v++) if (n_wr_v[v]) m_vars[v*WV +: WV] = n_vars[v*WV +: WV];
      for (int l = 0; l < NL; l++) if (n_wr_l[l]) m_lvls[l*WLS +: WLS] = n_lvls[l*WLS +: WLS];
    end
    if (n_ben) m_cur = n_base;
    if (idle && n_start) begin
      ref_verdict(s, u);
      vq.push_back('{edge_n: e + EL, sat: s, unsat: u});
      busy_lo = e + 1;
      busy_hi = e + EL + 1;
    end
    clear_next();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    clear_next();
    wr_carray_i = '0; rd_carray_i = '0; wr_var_states_i = '0; wr_lvl_states_i = '0;
    base_lvl_en_i = 1'b0; start_core_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic rd_was;
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_was <= 1'b0;
    else      rd_was <= |rd_carray_i;
  end

  // Monitor: pops expectations when the DUT presents a read result or a done pulse.
  always @(negedge clk) begin
    verdict_t ev;
    if (rst) begin
      if (rd_was) begin
        if (rdq.size() == 0) check("clause_rd_unexp", 160'd1, 160'd0);
        else check("clause_rd", clause_o, rdq.pop_front());
      end
      check("vars_states", vars_states_o, m_vars);
      check("lvl_states", lvl_states_o, m_lvls);
      check("cur_lvl", cur_lvl_o, m_cur);
      if (done_core_o) begin
        n_done++;
        if (vq.size() == 0) check("done_unexp", 160'(done_core_o), 160'd0);
        else begin
          ev = vq.pop_front();
          check("done_edge", 160'(cyc), 160'(ev.edge_n));
          check("local_sat", 160'(local_sat_o), 160'(ev.sat));
          check("local_unsat", 160'(local_unsat_o), 160'(ev.unsat));
        end
      end
    end
  end

  initial begin
    int d0;
    clear_model();
    clear_next();
    reset_dut();
    check("rst_clause_o", clause_o, 160'd0);
    check("rst_done", 160'(done_core_o), 160'd0);
    check("rst_sat", 160'(local_sat_o), 160'd0);
    check("rst_unsat", 160'(local_unsat_o), 160'd0);

    // Write then read, lowest index wins, all-zero select holds
    n_wr_c = 8'b0000_1000; n_clause = 16'h8002; step();
    n_wr_c = 8'b0010_0000; n_clause = 16'h0140; step();
    n_rd = 8'b0010_0000; step(); #1;
    check("rd_row5", clause_o, 160'h0140);
    n_rd = 8'b0010_1000; step(); #1;
    check("rd_lowest", clause_o, 160'h8002);
    step(); #1;
    check("rd_hold", clause_o, 160'h8002);
    n_rd = 8'b0000_1000; n_wr_c = 8'b0000_1000; n_clause = 16'h1111; step(); #1;
    check("rd_old_data", clause_o, 160'h8002);

    // Sat
    n_wr_c = 8'hFF; n_clause = 16'h0000; step();
    n_wr_c = 8'b0000_0001; n_clause = 16'h0002; step();
    n_wr_c = 8'b0000_0010; n_clause = 16'h0024;
    n_wr_v = 8'h07;
    for (int v = 0; v < 3; v++) n_vars[v*WV +: WV] = 19'h40000;
    step();
    n_start = 1'b1; step();
    idle_steps(7);
    check("sat_verdict", {local_sat_o, local_unsat_o}, 160'b10);

    // Unsat, then undetermined
    n_wr_c = 8'hFF; n_clause = 16'h0000; step();
    n_wr_c = 8'b0000_0001; n_clause = 16'h000A;
    n_wr_v = 8'h03; n_vars[0 +: WV] = 19'h20000; n_vars[WV +: WV] = 19'h20000;
    n_start = 1'b1; step();
    idle_steps(7);
    check("unsat_verdict", {local_sat_o, local_unsat_o}, 160'b01);
    n_wr_v = 8'h02; n_vars[WV +: WV] = 19'h00000; step();
    n_start = 1'b1; step();
    idle_steps(7);
    check("free_verdict", {local_sat_o, local_unsat_o}, 160'b00);

    // Lockout during RUN
    d0 = n_done;
    n_start = 1'b1; step();
    n_wr_c = 8'b0000_0001; n_clause = 16'h5555; n_start = 1'b1; step();
    idle_steps(7);
    n_rd = 8'b0000_0001; step(); #1;
    check("lockout_row0", clause_o, 160'h000A);
    check("lockout_one_done", 160'(n_done - d0), 160'd1);
    n_wr_c = 8'b0000_0001; n_clause = 16'h0280; step();
    n_rd = 8'b0000_0001; step(); #1;
    check("post_done_write", clause_o, 160'h0280);

    // Lvl state and base level
    n_wr_l = 8'h04; n_lvls[22 +: WLS] = {10'd7, 1'b1};
    n_ben = 1'b1; n_base = 16'd3; step(); #1;
    check("lvl_entry2", 160'(lvl_states_o[32:22]), 160'h00F);
    check("cur_lvl_3", cur_lvl_o, 160'd3);

    // Reset mid-RUN aborts without done, then the FSM is usable again
    d0 = n_done;
    n_start = 1'b1; step();
    idle_steps(2);
    reset_dut();
    idle_steps(8);
    check("abort_no_done", 160'(n_done - d0), 160'd0);
    n_start = 1'b1; step();
    idle_steps(7);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 2) == 0) n_wr_c = NC'($urandom);
      for (int v = 0; v < NV; v++) begin
        case ($urandom_range(0, 5))
          0: n_clause[2*v +: 2] = 2'b10;
          1: n_clause[2*v +: 2] = 2'b01;
          2: n_clause[2*v +: 2] = 2'b11;
          default: n_clause[2*v +: 2] = 2'b00;
        endcase
        case ($urandom_range(0, 2))
          0: n_vars[v*WV +: WV] = {2'b10, 17'($urandom)};
          1: n_vars[v*WV +: WV] = {2'b01, 17'($urandom)};
          default: n_vars[v*WV +: WV] = {2'b00, 17'($urandom)};
        endcase
      end
      if ($urandom_range(0, 1) == 0) n_rd = NC'($urandom);
      if ($urandom_range(0, 2) == 0) n_wr_v = NV'($urandom);
      if ($urandom_range(0, 3) == 0) n_wr_l = NL'($urandom);
      for (int l = 0; l < NL; l++) n_lvls[l*WLS +: WLS] = WLS'($urandom);
      n_ben = 1'($urandom);
      n_base = WL'($urandom);
      n_start = ($urandom_range(0, 5) == 0);
      step();
    end
    idle_steps(10);
    check("verdicts_drained", 160'(vq.size()), 160'd0);
    check("reads_drained", 160'(rdq.size()), 160'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
